// File: rtl/age_ordered_rs_pkg.sv
// Shared widths, the "no dependency" tag and the ALU op encoding used by the
// reservation station and its neighbours in the core.
package age_ordered_rs_pkg;

  localparam int DEF_ROB_IDX_W = 4;
  localparam int DEF_OP_W      = 6;
  localparam int DEF_DATA_W    = 32;

  // A producer tag of zero means the operand value is already present.
  localparam int READY_TAG     = 0;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;

endpackage

// File: rtl/age_ordered_rs_age_matrix.sv
// Age matrix for the reservation station: tracks relative issue order of the
// occupied slots and picks the oldest ready one as a one-hot select.
module rs_age_matrix #(
  parameter int RS_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [RS_DEPTH-1:0] busy_i,
  input  logic [RS_DEPTH-1:0] ready_i,
  input  logic [RS_DEPTH-1:0] alloc_i,
  output logic [RS_DEPTH-1:0] sel_o,
  output logic                any_ready_o
);

  // older_q[j][i] set means slot j was issued before slot i.
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] older_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] blocked;

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    older_d = older_q;
    for (int k = 0; k < RS_DEPTH; k++) begin
      if (alloc_i[k]) begin
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (j != k) older_d[j][k] = busy_i[j];
        end
        // Stale column bits of freed slots are harmless: selection masks by ready.
        older_d[k] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  always_comb begin
    blocked = '0;
    sel_o   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        blocked[i] = blocked[i] | (ready_i[j] & older_q[j][i]);
      end
      sel_o[i] = ready_i[i] & ~blocked[i];
    end
  end

  assign any_ready_o = |ready_i;

endmodule

// File: rtl/age_ordered_rs.sv
// ALU reservation station: lowest-free-slot allocation, CDB wakeup and issue
// bypass, oldest-ready selection into a valid/ready dispatch register.
module age_ordered_rs
  import age_ordered_rs_pkg::*;
#(
  parameter  int RS_DEPTH  = 16,
  parameter  int CDB_PORTS = 2,
  parameter  int ROB_IDX_W = DEF_ROB_IDX_W,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int OP_W      = DEF_OP_W,
  localparam int CNT_W     = $clog2(RS_DEPTH + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clr_in,

  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [ROB_IDX_W-1:0]          issue_rob_index,
  input  logic [OP_W-1:0]               issue_op,
  input  logic [DATA_W-1:0]             issue_rs1_val,
  input  logic [DATA_W-1:0]             issue_rs2_val,
  input  logic [ROB_IDX_W-1:0]          issue_rs1_depend,
  input  logic [ROB_IDX_W-1:0]          issue_rs2_depend,
  input  logic [DATA_W-1:0]             issue_imm,
  input  logic [DATA_W-1:0]             issue_PC,

  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_rob_index,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_result,

  output logic                          disp_valid,
  input  logic                          disp_ready,
  output logic [OP_W-1:0]               disp_op,
  output logic [DATA_W-1:0]             disp_rs1,
  output logic [DATA_W-1:0]             disp_rs2,
  output logic [ROB_IDX_W-1:0]          disp_rob_index,
  output logic [DATA_W-1:0]             disp_PC,
  output logic [DATA_W-1:0]             disp_imm,

  output logic [CNT_W-1:0]              rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam logic [ROB_IDX_W-1:0] NO_DEP = ROB_IDX_W'(READY_TAG);

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [ROB_IDX_W-1:0] rob;
    logic [DATA_W-1:0]    rs1_val;
    logic [ROB_IDX_W-1:0] rs1_dep;
    logic [DATA_W-1:0]    rs2_val;
    logic [ROB_IDX_W-1:0] rs2_dep;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [ROB_IDX_W-1:0] rob;
    logic [DATA_W-1:0]    rs1;
    logic [DATA_W-1:0]    rs2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
  } disp_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] val;
  } cdb_hit_t;

  function automatic cdb_hit_t cdb_lookup(
    input logic [ROB_IDX_W-1:0]           tag,
    input logic [CDB_PORTS-1:0]           valid,
    input logic [CDB_PORTS*ROB_IDX_W-1:0] tags,
    input logic [CDB_PORTS*DATA_W-1:0]    results
  );
    cdb_hit_t res;
    res = '0;
    if (tag != NO_DEP) begin
      // Scanning high to low lets the lowest matching port win.
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (valid[p] && tags[p*ROB_IDX_W +: ROB_IDX_W] == tag) begin
          res.hit = 1'b1;
          res.val = results[p*DATA_W +: DATA_W];
        end
      end
    end
    return res;
  endfunction

  logic [RS_DEPTH-1:0] busy_q, busy_d;
  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  logic                disp_valid_q;
  disp_t               disp_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                flush;
  logic                issue_fire;
  logic                load_ok;
  logic                disp_fire;
  logic                any_ready;
  logic [RS_DEPTH-1:0] alloc_oh;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] sel_oh;
  logic [RS_DEPTH-1:0] retire_oh;
  logic [IDX_W-1:0]    sel_idx;
  cdb_hit_t            byp1, byp2, wake1, wake2;

  assign flush       = rst_in | clr_in;
  assign issue_ready = ~&busy_q;
  assign issue_fire  = rdy_in & issue_valid & issue_ready;
  assign load_ok     = ~disp_valid_q | disp_ready;
  assign disp_fire   = rdy_in & load_ok & any_ready;
  assign retire_oh   = disp_fire ? sel_oh : '0;

  always_comb begin
    alloc_oh = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_q[i] && alloc_oh == '0) alloc_oh[i] = issue_fire;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = busy_q[i] && ent_q[i].rs1_dep == NO_DEP && ent_q[i].rs2_dep == NO_DEP;
    end
  end

  rs_age_matrix #(
    .RS_DEPTH (RS_DEPTH)
  ) u_age_matrix (
    .clk_i       (clk_in),
    .rst_i       (flush),
    .busy_i      (busy_q),
    .ready_i     (ready_vec),
    .alloc_i     (alloc_oh),
    .sel_o       (sel_oh),
    .any_ready_o (any_ready)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    busy_d = busy_q;
    ent_d  = ent_q;
    wake1  = '0;
    wake2  = '0;
    byp1   = cdb_lookup(issue_rs1_depend, cdb_valid, cdb_rob_index, cdb_result);
    byp2   = cdb_lookup(issue_rs2_depend, cdb_valid, cdb_rob_index, cdb_result);
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake1 = cdb_lookup(ent_q[i].rs1_dep, cdb_valid, cdb_rob_index, cdb_result);
      wake2 = cdb_lookup(ent_q[i].rs2_dep, cdb_valid, cdb_rob_index, cdb_result);
      if (busy_q[i] && wake1.hit) begin
        ent_d[i].rs1_val = wake1.val;
        ent_d[i].rs1_dep = NO_DEP;
      end
      if (busy_q[i] && wake2.hit) begin
        ent_d[i].rs2_val = wake2.val;
        ent_d[i].rs2_dep = NO_DEP;
      end
      if (retire_oh[i]) busy_d[i] = 1'b0;
      if (alloc_oh[i]) begin
        busy_d[i]        = 1'b1;
        ent_d[i].op      = issue_op;
        ent_d[i].rob     = issue_rob_index;
        ent_d[i].rs1_val = byp1.hit ? byp1.val : issue_rs1_val;
        ent_d[i].rs1_dep = byp1.hit ? NO_DEP   : issue_rs1_depend;
        ent_d[i].rs2_val = byp2.hit ? byp2.val : issue_rs2_val;
        ent_d[i].rs2_dep = byp2.hit ? NO_DEP   : issue_rs2_depend;
        ent_d[i].imm     = issue_imm;
        ent_d[i].pc      = issue_PC;
      end
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(issue_fire) - CNT_W'(disp_fire);
  end

  always_ff @(posedge clk_in) begin
    if (flush) begin
      busy_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry payloads are only meaningful under busy_q, so this storage is deliberately left without reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) ent_q <= ent_d;
  end

  always_ff @(posedge clk_in) begin
    if (flush) begin
      disp_valid_q <= 1'b0;
      disp_q       <= '0;
    end else if (rdy_in && load_ok) begin
      disp_valid_q <= any_ready;
      if (any_ready) begin
        disp_q.op  <= ent_q[sel_idx].op;
        disp_q.rob <= ent_q[sel_idx].rob;
        disp_q.rs1 <= ent_q[sel_idx].rs1_val;
        disp_q.rs2 <= ent_q[sel_idx].rs2_val;
        disp_q.imm <= ent_q[sel_idx].imm;
        disp_q.pc  <= ent_q[sel_idx].pc;
      end
    end
  end

  assign disp_valid     = disp_valid_q;
  assign disp_op        = disp_q.op;
  assign disp_rob_index = disp_q.rob;
  assign disp_rs1       = disp_q.rs1;
  assign disp_rs2       = disp_q.rs2;
  assign disp_imm       = disp_q.imm;
  assign disp_PC        = disp_q.pc;
  assign rs_count       = count_q;

endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: stimulus pushes expected dispatches into a
// queue, a negedge monitor pops and compares each accepted dispatch.
module tb_age_ordered_rs;
  import age_ordered_rs_pkg::*;

  localparam int RS_DEPTH  = 16;
  localparam int CDB_PORTS = 2;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int OP_W      = 6;
  localparam int CNT_W     = $clog2(RS_DEPTH + 1);

  logic                           clk_in;
  logic                           rst_in, rdy_in, clr_in;
  logic                           issue_valid, issue_ready;
  logic [ROB_IDX_W-1:0]           issue_rob_index;
  logic [OP_W-1:0]                issue_op;
  logic [DATA_W-1:0]              issue_rs1_val, issue_rs2_val;
  logic [ROB_IDX_W-1:0]           issue_rs1_depend, issue_rs2_depend;
  logic [DATA_W-1:0]              issue_imm, issue_PC;
  logic [CDB_PORTS-1:0]           cdb_valid;
  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_rob_index;
  logic [CDB_PORTS*DATA_W-1:0]    cdb_result;
  logic                           disp_valid, disp_ready;
  logic [OP_W-1:0]                disp_op;
  logic [DATA_W-1:0]              disp_rs1, disp_rs2, disp_PC, disp_imm;
  logic [ROB_IDX_W-1:0]           disp_rob_index;
  logic [CNT_W-1:0]               rs_count;

  age_ordered_rs #(
    .RS_DEPTH (RS_DEPTH), .CDB_PORTS (CDB_PORTS), .ROB_IDX_W (ROB_IDX_W),
    .DATA_W (DATA_W), .OP_W (OP_W)
  ) dut (
    .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in), .clr_in (clr_in),
    .issue_valid (issue_valid), .issue_ready (issue_ready),
    .issue_rob_index (issue_rob_index), .issue_op (issue_op),
    .issue_rs1_val (issue_rs1_val), .issue_rs2_val (issue_rs2_val),
    .issue_rs1_depend (issue_rs1_depend), .issue_rs2_depend (issue_rs2_depend),
    .issue_imm (issue_imm), .issue_PC (issue_PC),
    .cdb_valid (cdb_valid), .cdb_rob_index (cdb_rob_index), .cdb_result (cdb_result),
    .disp_valid (disp_valid), .disp_ready (disp_ready), .disp_op (disp_op),
    .disp_rs1 (disp_rs1), .disp_rs2 (disp_rs2), .disp_rob_index (disp_rob_index),
    .disp_PC (disp_PC), .disp_imm (disp_imm), .rs_count (rs_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [ROB_IDX_W-1:0] rob;
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    rs1;
    logic [DATA_W-1:0]    rs2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic [ROB_IDX_W-1:0] rob, input logic [OP_W-1:0] op,
                          input logic [DATA_W-1:0] rs1, input logic [DATA_W-1:0] rs2);
    exp_t e;
    e.rob = rob; e.op = op; e.rs1 = rs1; e.rs2 = rs2;
    exp_q.push_back(e);
  endtask

  // imm and PC are derived from the tag so the monitor can recompute them.
  task automatic issue(input logic [ROB_IDX_W-1:0] rob, input logic [OP_W-1:0] op,
                       input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                       input logic [ROB_IDX_W-1:0] d1, input logic [ROB_IDX_W-1:0] d2);
    issue_valid      = 1'b1;
    issue_rob_index  = rob;
    issue_op         = op;
    issue_rs1_val    = v1;
    issue_rs2_val    = v2;
    issue_rs1_depend = d1;
    issue_rs2_depend = d2;
    issue_imm        = 32'h1000 + 32'(rob);
    issue_PC         = 32'h8000 + 32'(rob) * 4;
    tick();
    issue_valid      = 1'b0;
  endtask

  // Monitor: every dispatch the ALU accepts must match the head of the queue.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in && !clr_in && rdy_in && disp_valid && disp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_dispatch: got rob %0d expected no dispatch", disp_rob_index);
      end else begin
        e = exp_q.pop_front();
        check("disp_rob", disp_rob_index, e.rob);
        check("disp_op", disp_op, e.op);
        check("disp_rs1", disp_rs1, e.rs1);
        check("disp_rs2", disp_rs2, e.rs2);
        check("disp_imm", disp_imm, 32'h1000 + 32'(e.rob));
        check("disp_pc", disp_PC, 32'h8000 + 32'(e.rob) * 4);
      end
    end
    if (cdb_valid[0] && cdb_valid[1] && cdb_rob_index[3:0] == cdb_rob_index[7:4]) begin
      n_errors++;
      $display("FAIL cdb_protocol: got two valid ports with tag %0d expected distinct tags", cdb_rob_index[3:0]);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; disp_ready = 1'b0;
    issue_valid = 1'b0; issue_rob_index = '0; issue_op = '0;
    issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_depend = '0; issue_rs2_depend = '0;
    issue_imm = '0; issue_PC = '0;
    cdb_valid = '0; cdb_rob_index = '0; cdb_result = '0;
    tick(); tick();
    rst_in = 1'b0;
    check("reset_count", rs_count, 0);
    check("reset_disp_valid", disp_valid, 0);
    check("reset_issue_ready", issue_ready, 1);
    check("reset_disp_rob", disp_rob_index, 0);
    check("reset_disp_rs1", disp_rs1, 0);
    check("reset_disp_pc", disp_PC, 0);

    // Single ready instruction: one cycle residency, then dispatch.
    disp_ready = 1'b1;
    push_exp(3, OP_ADD, 5, 7);
    issue(3, OP_ADD, 5, 7, 0, 0);
    check("t1_residency", disp_valid, 0);
    check("t1_count_issued", rs_count, 1);
    tick();
    check("t1_disp_valid", disp_valid, 1);
    check("t1_disp_rob", disp_rob_index, 3);
    check("t1_count_done", rs_count, 0);
    tick();
    check("t1_idle", disp_valid, 0);

    // Dependent entry waits for CDB port 1; younger ready entry goes first.
    push_exp(4, OP_SUB, 10, 20);
    push_exp(2, OP_ADD, 32'hDEAD, 3);
    issue(2, OP_ADD, 32'h111, 3, 9, 0);
    issue(4, OP_SUB, 10, 20, 0, 0);
    cdb_valid = 2'b10; cdb_rob_index = {4'd9, 4'd0}; cdb_result = {32'hDEAD, 32'h0};
    tick();
    cdb_valid = '0;
    check("t2_first_rob", disp_rob_index, 4);
    tick();
    check("t2_second_rob", disp_rob_index, 2);
    check("t2_second_rs1", disp_rs1, 32'hDEAD);
    tick();
    check("t2_count", rs_count, 0);

    // Same-cycle bypass from CDB port 0 at issue.
    push_exp(5, OP_XOR, 1, 42);
    cdb_valid = 2'b01; cdb_rob_index = {4'd0, 4'd6}; cdb_result = {32'h0, 32'd42};
    issue(5, OP_XOR, 1, 32'hBAD, 0, 6);
    cdb_valid = '0;
    check("t3_count", rs_count, 1);
    tick();
    check("t3_bypass_valid", disp_valid, 1);
    check("t3_bypass_rs2", disp_rs2, 42);
    tick();

    // Age order: slots 0..3, free slot 0, reissue into slot 0, wake all together.
    issue(10, OP_ADD, 0, 1, 5, 0);
    issue(11, OP_ADD, 0, 2, 7, 0);
    issue(12, OP_ADD, 3, 0, 0, 8);
    issue(13, OP_ADD, 0, 4, 7, 0);
    check("t4_filled", rs_count, 4);
    push_exp(10, OP_ADD, 32'h50, 1);
    cdb_valid = 2'b01; cdb_rob_index = {4'd0, 4'd5}; cdb_result = {32'h0, 32'h50};
    tick();
    cdb_valid = '0;
    tick();
    check("t4_slot0_out", disp_rob_index, 10);
    issue(14, OP_OR, 6, 0, 0, 7);
    check("t4_refilled", rs_count, 4);
    push_exp(11, OP_ADD, 32'h70, 2);
    push_exp(12, OP_ADD, 3, 32'h80);
    push_exp(13, OP_ADD, 32'h70, 4);
    push_exp(14, OP_OR, 6, 32'h70);
    cdb_valid = 2'b11; cdb_rob_index = {4'd8, 4'd7}; cdb_result = {32'h80, 32'h70};
    tick();
    cdb_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_b2b_valid", disp_valid, 1);
      check("t4_b2b_count", rs_count, 3 - k);
    end
    tick();
    check("t4_idle", disp_valid, 0);

    // Back-pressure: dispatch register holds, a frozen cycle changes nothing.
    disp_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_exp(4'(k), OP_AND, 32'h100 + 32'(k), 32'(k));
      issue(4'(k), OP_AND, 32'h100 + 32'(k), 32'(k), 0, 0);
    end
    check("t5_count", rs_count, 3);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t5_hold_rob", disp_rob_index, 1);
      check("t5_hold_count", rs_count, 3);
    end
    rdy_in = 1'b0;
    issue(9, OP_ADD, 0, 0, 0, 0);
    rdy_in = 1'b1;
    check("t5_frozen_count", rs_count, 3);
    check("t5_frozen_valid", disp_valid, 1);
    tick(); tick();
    check("t5_hold_rs1", disp_rs1, 32'h101);
    disp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_release_valid", disp_valid, 1);
      check("t5_release_count", rs_count, 2 - k);
    end
    tick();
    check("t5_drained", disp_valid, 0);

    // Full station drops extra issue; clear flushes even a stalled dispatch.
    disp_ready = 1'b0;
    issue(1, OP_ADD, 1, 1, 0, 0);
    tick();
    check("t6_stalled_valid", disp_valid, 1);
    for (int k = 0; k < RS_DEPTH; k++) begin
      check("t6_ready_while_filling", issue_ready, 1);
      issue(4'(k), OP_ADD, 0, 0, 15, 0);
    end
    check("t6_full_ready", issue_ready, 0);
    check("t6_full_count", rs_count, 16);
    issue(12, OP_ADD, 0, 0, 0, 0);
    check("t6_drop_count", rs_count, 16);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check("t6_clr_count", rs_count, 0);
    check("t6_clr_valid", disp_valid, 0);
    check("t6_clr_ready", issue_ready, 1);

    // Station still works after the flush.
    disp_ready = 1'b1;
    push_exp(7, OP_SLT, 70, 71);
    issue(7, OP_SLT, 70, 71, 0, 0);
    tick();
    check("t7_after_clr_valid", disp_valid, 1);
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised ALU reservation station sitting between the issue stage and the ALU, with CDB wakeup from any number of result buses. Entries are selected oldest-first through an age matrix instead of lowest-index-first. Issue-time operand bypass from the CDB is built in. The dispatch side is a valid/ready handshake, so a stalled or multi-cycle ALU never loses an instruction.

## Interface
Parameters:
- RS_DEPTH, 16, number of entries (2..32)
- CDB_PORTS, 2, number of result broadcast buses (1..4)
- ROB_IDX_W, 4, ROB tag width; tag 0 means "value ready, no dependency"
- DATA_W, 32, operand/immediate/PC width
- OP_W, 6, op-enum width

Ports (one clock; reset is synchronous and active-high):
- clk_in, in, 1, clock
- rst_in, in, 1, synchronous active-high reset
- rdy_in, in, 1, global enable; low freezes all state
- clr_in, in, 1, misprediction flush, same effect as reset
- issue_valid, in, 1, issue request
- issue_ready, out, 1, at least one free entry (from registered state)
- issue_rob_index, in, ROB_IDX_W, destination tag
- issue_op, in, OP_W, operation
- issue_rs1_val / issue_rs2_val, in, DATA_W, operand values
- issue_rs1_depend / issue_rs2_depend, in, ROB_IDX_W, producer tags (0 = ready)
- issue_imm, in, DATA_W, immediate
- issue_PC, in, DATA_W, PC
- cdb_valid, in, CDB_PORTS, per-port broadcast valid
- cdb_rob_index, in, CDB_PORTS*ROB_IDX_W, packed tags; port p at bits [p*ROB_IDX_W +: ROB_IDX_W]
- cdb_result, in, CDB_PORTS*DATA_W, packed results, same packing
- disp_valid, out, 1, dispatch register holds an instruction
- disp_ready, in, 1, ALU accepts this cycle
- disp_op, disp_rs1, disp_rs2, disp_rob_index, disp_PC, disp_imm, out, dispatched fields
- rs_count, out, $clog2(RS_DEPTH+1), occupied entries

## Operation
- Reset or clr_in: all busy bits clear, age matrix cleared, disp_valid=0, all disp_* fields=0, rs_count=0. issue_ready therefore reads 1.
- rdy_in=0 (and no reset/clr): no state changes. Issue and CDB inputs are ignored. disp_* holds.
- Issue: accepted when issue_valid && issue_ready. Written to the lowest-index free entry.
- Issue bypass: if an issue depend tag is nonzero and matches a valid CDB port in the same cycle, store that port's result and set depend=0.
- Wakeup: for every busy entry and each operand with nonzero depend equal to a valid cdb_rob_index[p], capture cdb_result[p] and set depend=0. If several ports match, the lowest p wins (protocol says it cannot happen; the bench asserts).
- Ready entry: busy && rs1_depend==0 && rs2_depend==0, evaluated on registered state. A wakeup only makes an entry eligible from the next cycle.
- Selection: the oldest ready entry per the age matrix. older[j][i]=1 means j was issued before i.
- Age matrix update on issue into slot k: older[j][k]=busy[j] for all j≠k, and older[k][j]=0.
- Dispatch register loads when (!disp_valid || disp_ready) and a ready entry exists. The selected entry is freed on that edge.
- If it may load and nothing is ready: disp_valid<=0.
- If disp_valid && !disp_ready: hold all disp_* fields, select nothing.
- rs_count: +1 on accepted issue, −1 on entry freed. Both on the same edge leaves it unchanged.
- Issue while full is dropped (issue_ready=0). The slot freed this cycle is not visible until the next cycle.

## Timing
- Issue accepted at edge E with ready operands: eligible in cycle E+1, disp_valid high after edge E+1. Minimum residency is one cycle.
- CDB wakeup at edge E: entry is dispatched at edge E+1 at the earliest.
- Back-to-back dispatch is supported: one instruction per cycle while disp_ready=1.
- issue_ready is a function of registered busy bits only, with no combinational path from issue_valid or disp_ready.
- clr_in at any cycle, including with disp_valid && !disp_ready: the next cycle has disp_valid=0 and an empty station.

## Structure
- Shared package/defines: ROB tag width, the ready-tag constant 0, op-enum width, and default DATA_W. These stay consistent with the rest of the core.
- Sub-module rs_age_matrix(RS_DEPTH): holds older[][]. Inputs are busy, ready vector, and alloc one-hot. Outputs are a one-hot oldest-ready select and any_ready.
- Free-slot select and the CDB compare are local for-loops in the top.

## Test plan
- Reset then issue tag 3 (ADD, rs1=5, rs2=7, depend 0/0) at cycle 1 with disp_ready=1 -> disp_valid at cycle 3, disp_rs1=5, disp_rs2=7, disp_rob_index=3; rs_count returns to 0.
- Issue tag 2 dependent on tag 9 (rs1_depend=9), then tag 4 ready. Broadcast cdb port 1 tag 9 result 0xDEAD -> tag 4 dispatches first; tag 2 dispatches after with disp_rs1=0xDEAD.
- Same-cycle bypass: issue with rs2_depend=6 while cdb port 0 carries tag 6 value 42 -> entry never waits; disp_rs2=42 two cycles later.
- Age order: fill entries 0..3, free entry 0, reissue into slot 0, make all ready -> dispatch order is original entries 1, 2, 3, then slot 0.
- Hold disp_ready=0 for 5 cycles with 3 ready entries -> disp_* stable, rs_count=3; release -> 3 dispatches in 3 consecutive cycles.
- Fill to RS_DEPTH -> issue_ready=0 and an extra issue is dropped (count stays 16). Assert clr_in -> next cycle count=0, disp_valid=0, issue_ready=1.
